// File: rtl/scan_counter.sv
// scan_counter: display digit scanner.
// A prescaler divides clk down to scan steps. Each step moves the digit index
// up or down, modulo NDIG. The index drives an active-low one-hot anode select.
// Sync load takes priority over stepping. Async active-low reset.
module scan_counter #(
    parameter  int NDIG     = 4,
    parameter  int PRESCALE = 100000,
    localparam int CW       = (NDIG > 2) ? $clog2(NDIG) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            up,
    input  logic            load,
    input  logic [CW-1:0]   load_val,
    output logic [CW-1:0]   count,
    output logic [NDIG-1:0] anode,
    output logic            tick,
    output logic            wrap
);

    // The prescaler width is sized to hold PRESCALE-1. PRESCALE=1 still gets one bit.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
    // One extra bit so the out-of-range test also works when NDIG == 2**CW.
    localparam logic [CW:0]   NDIG_EXT = (CW + 1)'(NDIG);

    logic [PW-1:0] pre;
    logic          step;
    logic [CW-1:0] count_step;
    logic          wrap_step;
    logic [CW-1:0] load_safe;

    // A scan step happens on the last prescaler phase of an enabled, non-load edge.
    assign step = en && !load && (pre == PRE_LAST);

    // An out-of-range load value falls back to digit 0, so count stays below NDIG.
    assign load_safe = ({1'b0, load_val} >= NDIG_EXT) ? '0 : load_val;

    // Next digit index and wrap flag for a step in the current direction.
    always_comb begin
        // NOTE: give every combinational output a default first; a path that
        // leaves it unassigned would infer a latch.
        count_step = count;
        wrap_step  = 1'b0;
        if (up) begin
            if (count == CNT_LAST) begin
                count_step = '0;
                wrap_step  = 1'b1;
            end else begin
                count_step = count + CW'(1);
            end
        end else begin
            if (count == '0) begin
                count_step = CNT_LAST;
                wrap_step  = 1'b1;
            end else begin
                count_step = count - CW'(1);
            end
        end
    end

    // Prescaler: counts enabled edges 0..PRESCALE-1. A load restarts the phase.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then
        // samples values from before the edge, whatever order the blocks run in.
        if (!reset) begin
            pre <= '0;
        end else if (load) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
    end

    // Digit index plus registered tick and wrap pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_safe;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (step) begin
            count <= count_step;
            tick  <= 1'b1;
            wrap  <= wrap_step;
        end else begin
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end
    end

    // Active-low one-hot decode of the current digit index.
    always_comb begin
        anode = '1;
        for (int i = 0; i < NDIG; i++) begin
            anode[i] = (count != CW'(i));
        end
    end

endmodule

// File: tb/tb_scan_counter.sv
// tb_scan_counter: two scan_counter instances share one set of stimulus inputs.
//   a: NDIG=4, PRESCALE=3
//   b: NDIG=3, PRESCALE=1
// A behavioural model built from modular arithmetic predicts both instances.
// It is compared on every falling edge. Directed checks use literal values.
module tb_scan_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [1:0] load_val;

    logic [1:0] count_a;
    logic [3:0] anode_a;
    logic       tick_a;
    logic       wrap_a;
    logic [1:0] count_b;
    logic [2:0] anode_b;
    logic       tick_b;
    logic       wrap_b;

    int errors = 0;
    int checks = 0;

    scan_counter #(.NDIG(4), .PRESCALE(3)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_a), .anode(anode_a),
        .tick(tick_a), .wrap(wrap_a)
    );

    scan_counter #(.NDIG(3), .PRESCALE(1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_b), .anode(anode_b),
        .tick(tick_b), .wrap(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Index 0 is instance a and index 1 is instance b.
    int nd [2] = '{4, 3};
    int ps [2] = '{3, 1};
    int m_pre [2];
    int m_cnt [2];
    bit m_tick [2];
    bit m_wrap [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_pre[i]  <= 0;
                m_cnt[i]  <= 0;
                m_tick[i] <= 1'b0;
                m_wrap[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_tick[i] <= 1'b0;
                m_wrap[i] <= 1'b0;
                if (load) begin
                    m_pre[i] <= 0;
                    m_cnt[i] <= (int'(load_val) >= nd[i]) ? 0 : int'(load_val);
                end else if (en) begin
                    if (m_pre[i] == ps[i] - 1) begin
                        m_pre[i]  <= 0;
                        m_tick[i] <= 1'b1;
                        if (up) begin
                            m_cnt[i]  <= (m_cnt[i] + 1) % nd[i];
                            m_wrap[i] <= (m_cnt[i] == nd[i] - 1);
                        end else begin
                            m_cnt[i]  <= (m_cnt[i] + nd[i] - 1) % nd[i];
                            m_wrap[i] <= (m_cnt[i] == 0);
                        end
                    end else begin
                        m_pre[i] <= m_pre[i] + 1;
                    end
                end
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        logic [3:0] exp_an_a;
        logic [2:0] exp_an_b;
        exp_an_a = ~(4'b0001 << m_cnt[0]);
        exp_an_b = 3'b111 & ~(3'b001 << m_cnt[1]);
        check("model_a_count", 32'(count_a), 32'(m_cnt[0]));
        check("model_a_tick",  32'(tick_a),  32'(m_tick[0]));
        check("model_a_wrap",  32'(wrap_a),  32'(m_wrap[0]));
        check("model_a_anode", 32'(anode_a), 32'(exp_an_a));
        check("model_b_count", 32'(count_b), 32'(m_cnt[1]));
        check("model_b_tick",  32'(tick_b),  32'(m_tick[1]));
        check("model_b_wrap",  32'(wrap_b),  32'(m_wrap[1]));
        check("model_b_anode", 32'(anode_b), 32'(exp_an_b));
    end

    // Advance one full clock. Return just after the falling edge.
    task automatic edge1();
        @(negedge clk);
        #1;
    endtask

    logic [1:0] up_cnt [4];
    logic [3:0] up_an  [4];

    initial begin
        up_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
        up_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
        #1;
        check("reset_count", 32'(count_a), 32'd0);
        check("reset_anode", 32'(anode_a), 32'b1110);
        edge1();
        edge1();
        reset = 1'b1;

        // Count up from reset: a steps on edges 3, 6, 9 and 12, and wraps on edge 12.
        for (int e = 1; e <= 12; e++) begin
            edge1();
            check("up_tick", 32'(tick_a), 32'((e % 3) == 0));
            check("up_wrap", 32'(wrap_a), 32'(e == 12));
            if ((e % 3) == 0) begin
                check("up_count", 32'(count_a), 32'(up_cnt[e/3 - 1]));
                check("up_anode", 32'(anode_a), 32'(up_an[e/3 - 1]));
            end
        end
        repeat (6) edge1();
        check("pre_reset_count", 32'(count_a), 32'd2);

        // Reset between edges clears count and anode at once.
        reset = 1'b0;
        #1;
        check("async_reset_count", 32'(count_a), 32'd0);
        check("async_reset_anode", 32'(anode_a), 32'b1110);
        up = 1'b0;
        edge1();
        reset = 1'b1;

        // Count down from reset: 0 -> 3 with wrap on edge 3, then 3 -> 2 without wrap on edge 6.
        for (int e = 1; e <= 6; e++) begin
            edge1();
            check("down_tick", 32'(tick_a), 32'((e % 3) == 0));
            if (e == 3) begin
                check("down_count3", 32'(count_a), 32'd3);
                check("down_wrap3",  32'(wrap_a),  32'd1);
            end
            if (e == 6) begin
                check("down_count6", 32'(count_a), 32'd2);
                check("down_wrap6",  32'(wrap_a),  32'd0);
            end
        end

        // Load one edge before a pending step. The step is suppressed and the phase restarts.
        edge1();
        edge1();
        load = 1'b1; load_val = 2'd2;
        edge1();
        check("load_count_a", 32'(count_a), 32'd2);
        check("load_tick_a",  32'(tick_a),  32'd0);
        check("load_count_b", 32'(count_b), 32'd2);
        load = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            edge1();
            check("post_load_tick", 32'(tick_a), 32'(e == 3));
        end
        check("post_load_count", 32'(count_a), 32'd1);

        // Out-of-range load on the 3-digit instance falls back to digit 0.
        load = 1'b1; load_val = 2'd3;
        edge1();
        check("oor_count_b", 32'(count_b), 32'd0);
        check("oor_anode_b", 32'(anode_b), 32'b110);
        check("oor_count_a", 32'(count_a), 32'd3);
        load = 1'b0; up = 1'b1;

        // Enable freeze at pre=1. The step lands two enabled edges after en returns.
        edge1();
        en = 1'b0;
        for (int e = 0; e < 5; e++) begin
            edge1();
            check("freeze_tick_a",  32'(tick_a),  32'd0);
            check("freeze_count_a", 32'(count_a), 32'd3);
            check("freeze_tick_b",  32'(tick_b),  32'd0);
        end
        en = 1'b1;
        edge1();
        check("resume_tick1", 32'(tick_a), 32'd0);
        edge1();
        check("resume_tick2",  32'(tick_a),  32'd1);
        check("resume_count2", 32'(count_a), 32'd0);
        check("resume_wrap2",  32'(wrap_a),  32'd1);

        // PRESCALE=1 ticks on every enabled edge after reset release.
        reset = 1'b0;
        edge1();
        reset = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            edge1();
            check("ps1_tick", 32'(tick_b), 32'd1);
            check("ps1_count", 32'(count_b), 32'(e % 3));
        end

        // Randomized traffic, including occasional reset pulses between edges.
        for (int c = 0; c < 3000; c++) begin
            en       = ($urandom_range(0, 9) != 0);
            up       = $urandom_range(0, 1) != 0;
            load     = ($urandom_range(0, 19) == 0);
            load_val = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
            edge1();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
